// File: rtl/cont_pkg.sv
// Shared types and constants for the bounce-counter monitor slice.
package cont_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    UP   = 3'd1,
    TOP  = 3'd2,
    DOWN = 3'd3,
    BOT  = 3'd4
  } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear; saturates at all-ones when sat_en=1, wraps otherwise.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         sat_en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  logic at_max_s;
  assign at_max_s = (cnt == ALL_ONES);

  // count register: clear wins over increment, saturation blocks the step at all-ones
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && !(sat_en && at_max_s)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bounce_seq_monitor.sv
// Checks a 0..MAX,MAX..0,0.. bounce sequence; flags illegal steps and counts turnarounds.
module bounce_seq_monitor
  import cont_pkg::*;
#(
  parameter int WIDTH  = CNT_W,
  parameter int TURN_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  s_in,
  input  logic              clr,
  output logic              locked,
  output logic              dir,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAXM_C = MAX_C - WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  mon_state_t       state_r;
  logic [WIDTH-1:0] prev_r;
  logic             have_prev_r;

  mon_state_t       nxt_state_s;
  logic             nxt_dir_s;
  logic             illegal_s;
  logic             turn_s;
  logic             up_step_s;
  logic             dn_step_s;
  logic [WIDTH:0]   prev_ext_s;
  logic [WIDTH:0]   s_ext_s;
  logic             err_inc_s;
  logic             turn_inc_s;

  // One extra bit keeps prev-1 at 0 and prev+1 at MAX out of the legal range.
  assign prev_ext_s = {1'b0, prev_r};
  assign s_ext_s    = {1'b0, s_in};
  assign up_step_s  = (s_ext_s == prev_ext_s + (WIDTH+1)'(1));
  assign dn_step_s  = (s_ext_s == prev_ext_s - (WIDTH+1)'(1));

  // next-state and legality decision for the current sample
  always_comb begin
    nxt_state_s = state_r;
    nxt_dir_s   = dir;
    illegal_s   = 1'b0;
    turn_s      = 1'b0;
    case (state_r)
      SYNC: begin
        if (have_prev_r && up_step_s) begin
          nxt_state_s = UP;
          nxt_dir_s   = 1'b0;
        end else if (have_prev_r && dn_step_s) begin
          nxt_state_s = DOWN;
          nxt_dir_s   = 1'b1;
        end else begin
          nxt_state_s = SYNC;
        end
      end
      UP: begin
        if (prev_r == MAX_C) begin
          if (s_in == MAX_C) begin
            nxt_state_s = TOP;
            nxt_dir_s   = 1'b1;
            turn_s      = 1'b1;
          end else begin
            illegal_s = 1'b1;
          end
        end else if (up_step_s) begin
          nxt_state_s = UP;
        end else begin
          illegal_s = 1'b1;
        end
      end
      TOP: begin
        if (s_in == MAXM_C) begin
          nxt_state_s = DOWN;
        end else begin
          illegal_s = 1'b1;
        end
      end
      DOWN: begin
        if (prev_r == ZERO_C) begin
          if (s_in == ZERO_C) begin
            nxt_state_s = BOT;
            nxt_dir_s   = 1'b0;
            turn_s      = 1'b1;
          end else begin
            illegal_s = 1'b1;
          end
        end else if (dn_step_s) begin
          nxt_state_s = DOWN;
        end else begin
          illegal_s = 1'b1;
        end
      end
      BOT: begin
        if (s_in == ONE_C) begin
          nxt_state_s = UP;
        end else begin
          illegal_s = 1'b1;
        end
      end
      default: begin
        nxt_state_s = SYNC;
      end
    endcase
    if (illegal_s) begin
      nxt_state_s = SYNC;
    end else begin
      nxt_state_s = nxt_state_s;
    end
  end

  assign err_inc_s  = en && !clr && illegal_s;
  assign turn_inc_s = en && !clr && turn_s;

  // tracking FSM with registered status outputs; clr behaves like reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= SYNC;
      prev_r      <= ZERO_C;
      have_prev_r <= 1'b0;
      locked      <= 1'b0;
      dir         <= 1'b0;
      err         <= 1'b0;
    end else if (clr) begin
      state_r     <= SYNC;
      prev_r      <= ZERO_C;
      have_prev_r <= 1'b0;
      locked      <= 1'b0;
      dir         <= 1'b0;
      err         <= 1'b0;
    end else if (en) begin
      state_r     <= nxt_state_s;
      prev_r      <= s_in;
      have_prev_r <= 1'b1;
      locked      <= (nxt_state_s != SYNC);
      dir         <= nxt_dir_s;
      err         <= illegal_s;
    end else begin
      err <= 1'b0;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (err_inc_s),
    .sat_en  (1'b1),
    .cnt     (err_cnt)
  );

  sat_counter #(.W(TURN_W)) u_turn_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (turn_inc_s),
    .sat_en  (1'b0),
    .cnt     (turn_cnt)
  );

endmodule

// File: tb/tb_bounce_seq_monitor.sv
// Directed bench for bounce_seq_monitor: a behavioural model fills a scoreboard per sample.
module tb_bounce_seq_monitor;

  logic       clock;
  logic       reset_n;
  logic       en;
  logic [3:0] s_in;
  logic       clr;
  logic       locked;
  logic       dir;
  logic [7:0] turn_cnt;
  logic       err;
  logic [3:0] err_cnt;

  typedef struct {
    logic       locked;
    logic       dir;
    logic [7:0] turn;
    logic       err;
    logic [3:0] errc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // model state: value-based expectation, not a copy of the FSM encoding
  int m_prev, m_turn, m_errc;
  bit m_have, m_locked, m_dir, m_hold, m_err;

  bounce_seq_monitor dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (en),
    .s_in     (s_in),
    .clr      (clr),
    .locked   (locked),
    .dir      (dir),
    .turn_cnt (turn_cnt),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_prev = 0; m_turn = 0; m_errc = 0;
    m_have = 0; m_locked = 0; m_dir = 0; m_hold = 0; m_err = 0;
  endtask

  task automatic model_step(input bit e, input bit c, input int s);
    int want;
    bit turn;
    exp_t x;
    m_err = 0;
    turn  = 0;
    want  = 0;
    if (c) begin
      model_reset();
    end else if (e) begin
      if (!m_have) begin
        m_have = 1;
      end else if (!m_locked) begin
        if (s == m_prev + 1) begin
          m_locked = 1; m_dir = 0; m_hold = 0;
        end else if (s == m_prev - 1) begin
          m_locked = 1; m_dir = 1; m_hold = 0;
        end
      end else begin
        if (!m_hold && !m_dir && m_prev == 15) begin
          want = 15; turn = 1;
        end else if (!m_hold && m_dir && m_prev == 0) begin
          want = 0; turn = 1;
        end else begin
          want = m_dir ? m_prev - 1 : m_prev + 1;
        end
        if (s == want) begin
          if (turn) begin
            m_dir  = !m_dir;
            m_hold = 1;
            m_turn = (m_turn + 1) % 256;
          end else begin
            m_hold = 0;
          end
        end else begin
          m_err    = 1;
          m_errc   = (m_errc < 15) ? m_errc + 1 : 15;
          m_locked = 0;
          m_hold   = 0;
        end
      end
      m_prev = s;
    end
    x.locked = m_locked;
    x.dir    = m_dir;
    x.turn   = 8'(m_turn);
    x.err    = m_err;
    x.errc   = 4'(m_errc);
    sb.push_back(x);
  endtask

  task automatic check_outputs(input exp_t x, input string tag);
    n_cmp++;
    assert (locked === x.locked) else begin
      n_fail++;
      $error("FAIL %s locked: got %b want %b", tag, locked, x.locked);
    end
    n_cmp++;
    assert (err === x.err) else begin
      n_fail++;
      $error("FAIL %s err: got %b want %b", tag, err, x.err);
    end
    n_cmp++;
    assert (turn_cnt === x.turn) else begin
      n_fail++;
      $error("FAIL %s turn_cnt: got %0d want %0d", tag, turn_cnt, x.turn);
    end
    n_cmp++;
    assert (err_cnt === x.errc) else begin
      n_fail++;
      $error("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, x.errc);
    end
    if (x.locked) begin
      n_cmp++;
      assert (dir === x.dir) else begin
        n_fail++;
        $error("FAIL %s dir: got %b want %b", tag, dir, x.dir);
      end
    end
  endtask

  task automatic drive(input bit e, input int s, input bit c, input string tag);
    exp_t x;
    @(negedge clock);
    en   = e;
    clr  = c;
    s_in = 4'(s);
    model_step(e, c, s);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    check_outputs(x, tag);
  endtask

  int   t1_q[$];
  exp_t zero_x;

  initial begin
    for (int v = 0; v <= 15; v++) t1_q.push_back(v);
    for (int v = 15; v >= 0; v--) t1_q.push_back(v);
    t1_q.push_back(0);
    t1_q.push_back(1);
    zero_x = '{locked: 1'b0, dir: 1'b0, turn: 8'd0, err: 1'b0, errc: 4'd0};

    reset_n = 1'b0; en = 1'b0; clr = 1'b0; s_in = 4'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_outputs(zero_x, "reset");
    n_cmp++;
    assert (dir === 1'b0) else begin
      n_fail++;
      $error("FAIL reset dir: got %b want 0", dir);
    end
    @(negedge clock);
    reset_n = 1'b1;

    // T1 full bounce, then T2 a skipped value while climbing
    foreach (t1_q[i]) drive(1'b1, t1_q[i], 1'b0, "t1");
    foreach (t1_q[i]) if (i < 4) drive(1'b1, 2 + i, 1'b0, "t2_pre");
    drive(1'b1, 6, 1'b0, "t2_6");
    drive(1'b1, 8, 1'b0, "t2_8");
    drive(1'b1, 9, 1'b0, "t2_9");
    drive(1'b1, 10, 1'b0, "t2_10");

    // T3 wrap from TOP to 0
    drive(1'b0, 0, 1'b1, "t3_clr");
    drive(1'b1, 13, 1'b0, "t3");
    drive(1'b1, 14, 1'b0, "t3");
    drive(1'b1, 15, 1'b0, "t3");
    drive(1'b1, 15, 1'b0, "t3_top");
    drive(1'b1, 0, 1'b0, "t3_wrap");
    drive(1'b1, 1, 1'b0, "t3_after");

    // T4 T1 again with idle cycles carrying junk values between samples
    drive(1'b0, 0, 1'b1, "t4_clr");
    foreach (t1_q[i]) begin
      drive(1'b0, $urandom_range(15, 0), 1'b0, "t4_idle");
      drive(1'b1, t1_q[i], 1'b0, "t4");
    end

    // T5 twenty errors, then clr with an illegal sample pending
    drive(1'b0, 0, 1'b1, "t5_clr");
    repeat (20) begin
      drive(1'b1, 5, 1'b0, "t5_lock");
      drive(1'b1, 6, 1'b0, "t5_lock");
      drive(1'b1, 12, 1'b0, "t5_bad");
    end
    drive(1'b1, 5, 1'b0, "t5_lock");
    drive(1'b1, 6, 1'b0, "t5_lock");
    drive(1'b1, 12, 1'b1, "t5_clr_bad");
    drive(1'b0, 0, 1'b0, "t5_idle");

    // T6 three turnarounds, then asynchronous reset between edges
    for (int v = 13; v <= 15; v++) drive(1'b1, v, 1'b0, "t6_up");
    for (int v = 15; v >= 0; v--) drive(1'b1, v, 1'b0, "t6_down");
    for (int v = 0; v <= 15; v++) drive(1'b1, v, 1'b0, "t6_up2");
    drive(1'b1, 15, 1'b0, "t6_top");
    drive(1'b1, 14, 1'b0, "t6_dn");
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(zero_x, "t6_async");
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b1, 7, 1'b0, "t6_relock");
    drive(1'b1, 8, 1'b0, "t6_relock");
    drive(1'b1, 9, 1'b0, "t6_relock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
